// File: rtl/rr_grant_ctrl_if.sv
// Bundles the controller's request, arbiter and ownership signals.
// The slave modport is the controller; the master modport is its environment.
interface rr_grant_ctrl_if #(
    parameter int N = 8
) ();
    localparam int M = $clog2(N);

    logic [N-1:0] i_req_pulse;
    logic [N-1:0] o_req;
    logic         o_en;
    logic [N-1:0] i_gnt;
    logic         o_busy;
    logic [M-1:0] o_owner;
    logic         o_start;
    logic [N-1:0] o_ovf;
    logic         o_err;

    modport slave (
        input  i_req_pulse, i_gnt,
        output o_req, o_en, o_busy, o_owner, o_start, o_ovf, o_err
    );

    modport master (
        output i_req_pulse, i_gnt,
        input  o_req, o_en, o_busy, o_owner, o_start, o_ovf, o_err
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Queues request pulses in saturating counters, runs one arbitration at a time,
// and holds the granted requester as resource owner for a fixed burst.
module rr_grant_ctrl #(
    parameter int N     = 8,
    parameter int CW    = 2,
    parameter int BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    rr_grant_ctrl_if.slave bus
);
    localparam int M  = $clog2(N);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] PEND_MAX   = '1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_WAIT, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [M-1:0]  owner_q, owner_d;
    logic [CW-1:0] pend_q [N];
    logic [CW-1:0] pend_d [N];
    logic [N-1:0]  ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [N-1:0]  retire;
    logic [N-1:0]  req;
    logic          gnt_onehot;
    logic [M-1:0]  gnt_idx;

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            state_q <= S_IDLE;
            burst_q <= '0;
            owner_q <= '0;
            ovf_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) pend_q[i] <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            owner_q <= owner_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            for (int i = 0; i < N; i++) pend_q[i] <= pend_d[i];
        end
    end

    // One request is retired for the owner in the last BUSY cycle.
    always_comb begin
        retire = '0;
        if (state_q == S_BUSY && burst_q == '0) retire[owner_q] = 1'b1;
    end

    // A pulse coinciding with a retire cancels out and cannot overflow.
    always_comb begin
        ovf_d = ovf_q;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            pend_d[i] = pend_q[i];
            req[i]    = (pend_q[i] != '0);
            if (bus.i_req_pulse[i] && !retire[i]) begin
                if (pend_q[i] == PEND_MAX) ovf_d[i] = 1'b1;
                else                       pend_d[i] = pend_q[i] + CW'(1);
            end else if (retire[i] && !bus.i_req_pulse[i] && pend_q[i] != '0) begin
                pend_d[i] = pend_q[i] - CW'(1);
            end
        end
    end

    always_comb begin
        gnt_idx    = '0;
        for (int i = 0; i < N; i++) if (bus.i_gnt[i]) gnt_idx = M'(i);
        gnt_onehot = (bus.i_gnt != '0) && ((bus.i_gnt & (bus.i_gnt - N'(1))) == '0);
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        owner_d = owner_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req != '0) state_d = S_ARB;
            S_ARB:  state_d = S_WAIT;
            S_WAIT: begin
                if (gnt_onehot) begin
                    owner_d = gnt_idx;
                    burst_d = BURST_LAST;
                    state_d = S_BUSY;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (burst_q == '0) state_d = S_IDLE;
                else               burst_d = burst_q - BW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_en    = (state_q == S_ARB);
        bus.o_busy  = (state_q == S_BUSY);
        bus.o_start = (state_q == S_BUSY) && (burst_q == BURST_LAST);
    end

    assign bus.o_req   = req;
    assign bus.o_owner = owner_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: a cycle-level behavioural model plus a round-robin
// arbiter stand-in, directed scenarios with literal expectations, then random traffic.
module tb_rr_grant_ctrl;
    localparam int N     = 8;
    localparam int CW    = 2;
    localparam int BURST = 4;
    localparam int PMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_grant_ctrl_if #(.N(N)) bus ();
    rr_grant_ctrl #(.N(N), .CW(CW), .BURST(BURST)) dut (
        .i_clk (clk),
        .i_rstn(rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         m_pend [N];
    logic [N-1:0] m_ovf;
    logic       m_err;
    int         m_owner;
    int         m_stage;   // 0 idle, 1 arbitrating, 2 awaiting grant
    int         m_left;    // burst cycles remaining, including the current one

    int         arb_ptr = N - 1;
    bit         arb_pending = 1'b0;
    int         arb_fault_q = 0;
    logic [N-1:0] arb_gnt = '0;
    int         gnt_fault = 0;   // 0 normal, 1 zero grant, 2 multi-hot grant

    int hook_owner = -1;
    bit hook_hit   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural reference: advance one clock using the inputs of the ending cycle.
    always @(posedge clk) begin : model
        int any;
        bit p, r;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_ovf = '0; m_err = 1'b0; m_owner = 0; m_stage = 0; m_left = 0;
        end else begin
            any = 0;
            for (int i = 0; i < N; i++) if (m_pend[i] != 0) any = 1;
            for (int i = 0; i < N; i++) begin
                p = bus.i_req_pulse[i];
                r = (m_left == 1) && (m_owner == i);
                if (p && !r) begin
                    if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
                    else                   m_pend[i]++;
                end else if (r && !p && m_pend[i] > 0) begin
                    m_pend[i]--;
                end
            end
            if (m_left > 0) m_left--;
            else if (m_stage == 0) begin
                if (any != 0) m_stage = 1;
            end else if (m_stage == 1) m_stage = 2;
            else begin
                m_stage = 0;
                if ($countones(bus.i_gnt) == 1) begin
                    for (int i = 0; i < N; i++) if (bus.i_gnt[i]) m_owner = i;
                    m_left = BURST;
                end else m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] e_req;
        if (chk_en) begin
            for (int i = 0; i < N; i++) e_req[i] = (m_pend[i] != 0);
            check("o_req",   32'(bus.o_req),   32'(e_req));
            check("o_en",    32'(bus.o_en),    32'(m_stage == 1));
            check("o_busy",  32'(bus.o_busy),  32'(m_left > 0));
            check("o_start", 32'(bus.o_start), 32'(m_left == BURST));
            check("o_owner", 32'(bus.o_owner), 32'(m_owner));
            check("o_ovf",   32'(bus.o_ovf),   32'(m_ovf));
            check("o_err",   32'(bus.o_err),   32'(m_err));
        end
    end

    // Round-robin arbiter stand-in: samples o_req in the o_en cycle, grants next cycle.
    always @(negedge clk) begin : arbiter
        bit found;
        int c;
        if (rst) begin
            arb_ptr = N - 1;
            arb_pending = 1'b0;
        end else if (bus.o_en === 1'b1) begin
            arb_gnt = '0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (arb_ptr + k) % N;
                if (!found && bus.o_req[c] === 1'b1) begin
                    arb_gnt[c] = 1'b1;
                    found = 1'b1;
                    if (gnt_fault == 0) arb_ptr = c;
                end
            end
            arb_fault_q = gnt_fault;
            arb_pending = 1'b1;
        end
    end

    task automatic step(input logic [N-1:0] pulse, input logic rst_v);
        @(posedge clk);
        #1;
        if (hook_owner >= 0 && m_left == 1 && m_owner == hook_owner) begin
            pulse[hook_owner] = 1'b1;
            hook_hit   = 1'b1;
            hook_owner = -1;
        end
        rst = rst_v;
        bus.i_req_pulse = pulse;
        if (arb_pending) begin
            case (arb_fault_q)
                1:       bus.i_gnt = '0;
                2:       bus.i_gnt = arb_gnt | {arb_gnt[N-2:0], arb_gnt[N-1]};
                default: bus.i_gnt = arb_gnt;
            endcase
            arb_pending = 1'b0;
        end else begin
            bus.i_gnt = '0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    initial begin
        int starts;
        int owners [3];
        int n_en, en_busy;
        logic [N-1:0] rp;

        bus.i_req_pulse = '0;
        bus.i_gnt = '0;
        step('0, 1'b1);
        step('0, 1'b1);
        chk_en = 1'b1;

        // Reset state, then one request on 3 with literal timing.
        step('0, 1'b0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_req",  32'(bus.o_req),  32'd0);
        check("rst_en",   32'(bus.o_en),   32'd0);
        step(8'b0000_1000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step('0, 1'b0);
            check("t1_en",    32'(bus.o_en),    32'(k == 2));
            check("t1_start", 32'(bus.o_start), 32'(k == 4));
            check("t1_busy",  32'(bus.o_busy),  32'(k >= 4 && k <= 7));
            check("t1_req3",  32'(bus.o_req[3]), 32'(k <= 7));
            if (k == 4) check("t1_owner", 32'(bus.o_owner), 32'd3);
        end
        check("t1_pend3", 32'(m_pend[3]), 32'd0);

        // Four pulses on requester 5: saturation, sticky overflow, three bursts.
        for (int k = 0; k < 4; k++) step(8'b0010_0000, 1'b0);
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            step('0, 1'b0);
            if (k == 0) begin
                check("t2_ovf5",  32'(bus.o_ovf[5]), 32'd1);
                check("t2_pend5", 32'(m_pend[5]),    32'd3);
            end
            if (bus.o_start === 1'b1 && bus.o_owner === 3'd5) starts++;
        end
        check("t2_bursts", 32'(starts), 32'd3);
        check("t2_req5",   32'(bus.o_req[5]), 32'd0);
        check("t2_ovf5_sticky", 32'(bus.o_ovf[5]), 32'd1);

        // Pulse on 2 in owner 2's last BUSY cycle while its counter is full.
        for (int k = 0; k < 3; k++) step(8'b0000_0100, 1'b0);
        hook_owner = 2;
        hook_hit   = 1'b0;
        for (int k = 0; k < 40 && !hook_hit; k++) step('0, 1'b0);
        check("t3_hook", 32'(hook_hit), 32'd1);
        hook_owner = -1;
        step('0, 1'b0);
        check("t3_ovf2",  32'(bus.o_ovf[2]), 32'd0);
        check("t3_pend2", 32'(m_pend[2]),    32'd3);
        idle(40);

        // Requests on 1, 4, 6 from a fresh reset: rotation order, one o_en per burst.
        step('0, 1'b1);
        step(8'b0101_0010, 1'b0);
        starts = 0; n_en = 0; en_busy = 0;
        for (int k = 0; k < 40; k++) begin
            step('0, 1'b0);
            if (bus.o_en === 1'b1) n_en++;
            if (bus.o_en === 1'b1 && bus.o_busy === 1'b1) en_busy++;
            if (bus.o_start === 1'b1 && starts < 3) begin
                owners[starts] = int'(bus.o_owner);
                starts++;
            end
        end
        check("t4_starts", 32'(starts), 32'd3);
        check("t4_own0", 32'(owners[0]), 32'd1);
        check("t4_own1", 32'(owners[1]), 32'd4);
        check("t4_own2", 32'(owners[2]), 32'd6);
        check("t4_n_en", 32'(n_en), 32'd3);
        check("t4_en_busy", 32'(en_busy), 32'd0);

        // Zero grant: error flag, back to IDLE, nothing retired, re-arbitrate.
        gnt_fault = 1;
        step(8'b0000_0001, 1'b0);
        idle(3);
        step('0, 1'b0);
        check("t5_err",  32'(bus.o_err),    32'd1);
        check("t5_en0",  32'(bus.o_en),     32'd0);
        check("t5_req0", 32'(bus.o_req[0]), 32'd1);
        gnt_fault = 0;
        step('0, 1'b0);
        check("t5_en1",  32'(bus.o_en),     32'd1);
        idle(20);

        // Reset in the second BUSY cycle of a burst.
        step('0, 1'b1);
        for (int k = 0; k < 4; k++) step(8'b0010_0000, 1'b0);
        step('0, 1'b0);
        check("t6_busy_pre", 32'(bus.o_busy), 32'd1);
        check("t6_ovf_pre",  32'(bus.o_ovf),  32'h20);
        step('0, 1'b1);
        step('0, 1'b0);
        check("t6_busy",  32'(bus.o_busy),  32'd0);
        check("t6_req",   32'(bus.o_req),   32'd0);
        check("t6_ovf",   32'(bus.o_ovf),   32'd0);
        check("t6_err",   32'(bus.o_err),   32'd0);
        check("t6_owner", 32'(bus.o_owner), 32'd0);

        // Random traffic with occasional bad grants and resets.
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) rp[i] = ($urandom_range(0, 5) == 0);
            gnt_fault = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
            step(rp, ($urandom_range(0, 299) == 0));
        end
        gnt_fault = 0;
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
